// File: rtl/t07_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : t07_wb_arbiter_if
// Brief    : CPU fetch/data request ports and Wishbone-manager command port.
// Revision : 1.0 - initial release
// ============================================================================
interface t07_wb_arbiter_if;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        f_ack_o;
  logic [31:0] f_rdata_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;

  logic        wb_read_o;
  logic        wb_write_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_wdata_o;
  logic [31:0] wb_rdata_i;
  logic        wb_busy_i;

  logic        stall_o;
  logic        err_o;

  // Arbiter side
  modport slave (
    input  f_req_i, f_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  wb_rdata_i, wb_busy_i,
    output f_ack_o, f_rdata_o, d_ack_o, d_rdata_o,
    output wb_read_o, wb_write_o, wb_addr_o, wb_wdata_o,
    output stall_o, err_o
  );

  // CPU / manager side
  modport master (
    output f_req_i, f_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output wb_rdata_i, wb_busy_i,
    input  f_ack_o, f_rdata_o, d_ack_o, d_rdata_o,
    input  wb_read_o, wb_write_o, wb_addr_o, wb_wdata_o,
    input  stall_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/t07_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t07_wb_arbiter
// Brief    : Round-robin fetch/data arbiter driving a single-command Wishbone
//            manager, with per-wait-state timeout and error read word.
// Revision : 1.0 - initial release
// ============================================================================
module t07_wb_arbiter #(
  parameter int unsigned TIMEOUT  = 200,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic            clk,
  input  logic            nrst,
  t07_wb_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  localparam logic [7:0] c_timeout   = 8'(TIMEOUT);
  localparam logic       c_gnt_fetch = 1'b0;
  localparam logic       c_gnt_data  = 1'b1;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        any_req;
  logic        gnt_pick;
  logic [7:0]  cnt_inc;
  logic        timeout_hit;
  logic        rdata_load;
  logic [31:0] rdata_fill;
  logic        f_ack;
  logic        d_ack;

  assign any_req     = bus.f_req_i | bus.d_req_i;
  // Data wins when alone, or on a tie when fetch was served last.
  assign gnt_pick    = bus.d_req_i & (~bus.f_req_i | (last_gnt_q == c_gnt_fetch));
  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == c_timeout);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    cnt_d      = 8'd0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    rdata_load = 1'b0;
    rdata_fill = bus.wb_rdata_i;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = gnt_pick;
          we_d    = gnt_pick & bus.d_we_i;
          addr_d  = gnt_pick ? bus.d_addr_i : bus.f_addr_i;
          wdata_d = gnt_pick ? bus.d_wdata_i : 32'd0;
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (bus.wb_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (timeout_hit) begin
          state_d    = ST_RESP;
          err_d      = 1'b1;
          rdata_load = ~we_q;
          rdata_fill = ERR_WORD;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WAIT_DONE: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (!bus.wb_busy_i) begin
          state_d    = ST_RESP;
          rdata_load = ~we_q;
        end else if (timeout_hit) begin
          state_d    = ST_RESP;
          err_d      = 1'b1;
          rdata_load = ~we_q;
          rdata_fill = ERR_WORD;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        last_gnt_d = gnt_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rdata_load) begin
      if (gnt_q == c_gnt_data) begin
        d_rdata_d = rdata_fill;
      end else begin
        f_rdata_d = rdata_fill;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= c_gnt_fetch;
      last_gnt_q <= c_gnt_fetch;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      f_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign f_ack = (state_q == ST_RESP) & (gnt_q == c_gnt_fetch);
  assign d_ack = (state_q == ST_RESP) & (gnt_q == c_gnt_data);

  assign bus.wb_read_o  = (state_q == ST_ISSUE) & ~we_q;
  assign bus.wb_write_o = (state_q == ST_ISSUE) & we_q;
  assign bus.wb_addr_o  = addr_q;
  assign bus.wb_wdata_o = wdata_q;
  assign bus.f_ack_o    = f_ack;
  assign bus.d_ack_o    = d_ack;
  assign bus.f_rdata_o  = f_rdata_q;
  assign bus.d_rdata_o  = d_rdata_q;
  assign bus.err_o      = (state_q == ST_RESP) & err_q;
  assign bus.stall_o    = (bus.f_req_i & ~f_ack) | (bus.d_req_i & ~d_ack);

endmodule
`default_nettype wire

// File: doc/t07_wb_arbiter.md
T07_WB_ARBITER -- requirements
Module: t07_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, max cycles allowed in each wait state before abort (1..255).
REQ-002 SHALL have parameter ERR_WORD, default 32'hDEADBEEF, read data returned on timeout.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 f_req_i  in  1  instruction-fetch request, held until f_ack_o.
REQ-006 f_addr_i  in  32  fetch address.
REQ-007 f_ack_o  out  1  one-cycle fetch completion pulse.
REQ-008 f_rdata_o  out  32  fetched instruction word.
REQ-009 d_req_i  in  1  load/store request, held until d_ack_o.
REQ-010 d_we_i  in  1  1 = store, 0 = load.
REQ-011 d_addr_i  in  32  data address.
REQ-012 d_wdata_i  in  32  store data.
REQ-013 d_ack_o  out  1  one-cycle data completion pulse.
REQ-014 d_rdata_o  out  32  load data.
REQ-015 wb_read_o / wb_write_o  out  1 each  one-cycle command strobes to the Wishbone manager.
REQ-016 wb_addr_o, wb_wdata_o  out  32 each  address and store data to the manager, passed through unmodified.
REQ-017 wb_rdata_i  in  32  read data from the manager.
REQ-018 wb_busy_i  in  1  manager busy.
REQ-019 stall_o  out  1  CPU stall.
REQ-020 err_o  out  1  one-cycle timeout pulse, coincident with the ack.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-022 IDLE: if any request is pending, SHALL latch grant, address, wdata and we into registers and go to ISSUE; otherwise stay in IDLE.
REQ-023 Arbitration SHALL be single-request-wins; with both pending, round-robin against last_grant (grant goes to the port not granted last).
REQ-024 ISSUE: SHALL assert exactly one of wb_read_o/wb_write_o for exactly one cycle (write iff data grant and we=1), then go to WAIT_BUSY.
REQ-025 wb_addr_o/wb_wdata_o SHALL come from the latched registers, stable from ISSUE through RESP.
REQ-026 WAIT_BUSY: wb_busy_i=1 SHALL go to WAIT_DONE.
REQ-027 WAIT_DONE: wb_busy_i=0 SHALL go to RESP; on a read, SHALL capture wb_rdata_i into the granted port's rdata register on that edge.
REQ-028 RESP: SHALL assert the granted port's ack for one cycle, update last_grant, and return to IDLE; no new grant is issued in RESP.
REQ-029 Minimum latency SHALL be 5 cycles from request to ack (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP), with 1-cycle manager busy.
REQ-030 An 8-bit wait counter SHALL clear on entering WAIT_BUSY and on entering WAIT_DONE, and increment each cycle in those states.
REQ-031 When the counter reaches TIMEOUT, the FSM SHALL go to RESP, pulse err_o with the ack, and load ERR_WORD into rdata on a read.
REQ-032 Store completion SHALL leave d_rdata_o unchanged.
REQ-033 f_rdata_o/d_rdata_o SHALL hold their last captured value until that port's next read completes.
REQ-034 A request dropped mid-transaction SHALL NOT abort it; the transaction completes and the ack still pulses.
REQ-035 A request held high through its ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-036 stall_o SHALL equal (f_req_i & ~f_ack_o) | (d_req_i & ~d_ack_o), combinational.

Reset
REQ-037 While nrst=0, the block SHALL force: state IDLE; last_grant = fetch (data wins the first tie); counter 0; all rdata registers 0; all strobes, acks and err_o 0.
REQ-038 Reset asserted mid-transaction SHALL abandon it immediately, with no ack and no strobe after release.

Verification
REQ-039 Fetch read: f_req_i=1, f_addr_i=0x100; manager busy 1 cycle with wb_rdata_i=0x00500093 -> one wb_read_o pulse, wb_addr_o=0x100, f_ack_o 5 cycles after the request, f_rdata_o=0x00500093.
REQ-040 Simultaneous requests after reset (fetch, plus data load 0x500) -> data served first, then fetch; both requests held -> alternation data, fetch, data.
REQ-041 Store: d_we_i=1, d_addr_i=0x600, d_wdata_i=0xCAFEF00D -> one wb_write_o pulse, wb_wdata_o=0xCAFEF00D, d_ack_o pulses, d_rdata_o unchanged.
REQ-042 Timeout: wb_busy_i never rises, TIMEOUT=4 -> ack with err_o=1 after 4 cycles in WAIT_BUSY, rdata=0xDEADBEEF; next request proceeds normally.
REQ-043 Reset mid-transaction: nrst low during WAIT_DONE -> all outputs 0 at once; after release, no ack until a new request.
